instr_encoder: RTL and testbench
================================

INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 Parameter ADDR_W, default 6, instruction-memory address width; DEPTH = 2**ADDR_W words.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  field bundle valid.
REQ-005 in_ready  output  1  encoder can accept a bundle.
REQ-006 cond  input  4  condition field for Instr[31:28].
REQ-007 op  input  2  opcode class for Instr[27:26]: 00 data-processing, 01 memory, 10 branch, 11 illegal.
REQ-008 funct  input  6  Funct field for Instr[25:20]; for branch only funct[5:4] is used.
REQ-009 rn, rd  input  4 each  register fields.
REQ-010 operand  input  24  Src2/imm12 in [11:0] for op 00/01; imm24 in [23:0] for op 10.
REQ-011 clear  input  1  synchronous pointer/flag clear.
REQ-012 mem_we  output  1  instruction-memory write strobe, one cycle per word.
REQ-013 mem_addr  output  ADDR_W  write address.
REQ-014 mem_wdata  output  32  encoded instruction.
REQ-015 word_count  output  ADDR_W+1  words written since reset/clear.
REQ-016 full, err  output  1 each  memory full; sticky illegal-bundle flag.

Function
REQ-017 Handshake: a bundle is accepted on a rising edge where in_valid & in_ready; in_ready = (state==IDLE) & ~clear & ~full.
REQ-018 Encoding, op 00/01: Instr = {cond, op, funct, rn, rd, operand[11:0]}.
REQ-019 Encoding, op 10: Instr = {cond, 2'b10, funct[5:4], operand[23:0]}.
REQ-020 Illegal: op==11 or cond==4'b1111 SHALL be accepted (handshake completes), SHALL NOT write memory, SHALL set err; FSM stays IDLE.
REQ-021 FSM states: IDLE, WRITE, FULL. IDLE -> WRITE on accepted legal bundle; WRITE -> IDLE after one cycle (or -> FULL per REQ-025).
REQ-022 Latency: encoded word registered at acceptance; mem_we=1 for exactly the single WRITE cycle with mem_wdata/mem_addr stable; throughput one word per 2 cycles.
REQ-023 mem_addr = write pointer; pointer and word_count increment at end of WRITE cycle.
REQ-024 mem_we=0 and mem_wdata holds last value in all non-WRITE cycles.
REQ-025 Boundary: when the DEPTH-th word is written, behaviour per REQ-031/032.
REQ-026 clear in any state: pointer=0, word_count=0, err=0, full=0, state=IDLE next edge; a WRITE cycle coinciding with clear still completes its mem_we pulse but pointer ends at 0; clear asserted with in_valid: bundle not accepted.

Reset
REQ-027 On reset low, immediately: state=IDLE, mem_we=0, mem_addr=0, mem_wdata=0, word_count=0, full=0, err=0; in_ready=0 while reset low.
REQ-028 Reset mid-WRITE aborts the write (mem_we drops asynchronously); no partial state persists.
REQ-029 First acceptance possible on the first rising edge after reset deasserts.

Configuration
REQ-030 Macro ENC_WRAP_EN selects full-memory behaviour.
REQ-031 With ENC_WRAP_EN defined: pointer wraps DEPTH-1 -> 0, word_count saturates at DEPTH, full never asserts, state returns to IDLE.
REQ-032 Without ENC_WRAP_EN: after DEPTH-th write, full=1, state=FULL, in_ready=0, until clear.

Verification
REQ-033 ADD R1,R2,#5: cond=1110, op=00, funct=101000, rn=2, rd=1, operand=0x005 -> one cycle later mem_we=1, mem_addr=0, mem_wdata=0xE2821005; word_count=1.
REQ-034 LDR R3,[R4,#8]: cond=1110, op=01, funct=011001, rn=4, rd=3, operand=0x008 -> mem_wdata=0xE5943008 at next address.
REQ-035 Branch: cond=1110, op=10, funct=10xxxx, operand=0x000003 -> mem_wdata=0xEA000003; rn/rd ignored.
REQ-036 op=11 bundle -> no mem_we, err=1 sticky, word_count unchanged; clear -> err=0.
REQ-037 ADDR_W=2, in_valid held high: 4 writes at addr 0..3; without macro full=1, in_ready=0; with macro 5th write at addr 0, full=0.
REQ-038 Assert reset low during WRITE cycle -> mem_we=0 immediately, all outputs at reset values; clear+in_valid same cycle -> no acceptance.

Source files
------------

// File: rtl/instr_encoder.sv
// Field-bundle to 32-bit instruction encoder that writes encoded words into instruction memory.
// Define ENC_WRAP_EN to make the write pointer wrap when memory is full instead of stalling.
module instr_encoder #(
  parameter int unsigned ADDR_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        cond,
  input  logic [1:0]        op,
  input  logic [5:0]        funct,
  input  logic [3:0]        rn,
  input  logic [3:0]        rd,
  input  logic [23:0]       operand,
  input  logic              clear,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [ADDR_W:0]   word_count,
  output logic              full,
  output logic              err
);

  localparam logic [ADDR_W:0] MaxCount = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [1:0] {StIdle, StWrite, StFull} state_e;

  state_e      state;
  logic        illegal;
  logic [31:0] enc;

  // reset gates in_ready so nothing looks acceptable while held in reset
  assign in_ready = reset & (state == StIdle) & ~clear & ~full;
  assign illegal  = (op == 2'b11) | (cond == 4'hF);

  always_comb begin
    enc = {cond, op, funct, rn, rd, operand[11:0]};
    if (op == 2'b10) begin
      enc = {cond, 2'b10, funct[5:4], operand};
    end
  end

  // mem_addr doubles as the write pointer; it advances as the WRITE cycle ends
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= StIdle;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      word_count <= '0;
      full       <= 1'b0;
      err        <= 1'b0;
    end else if (clear) begin
      state      <= StIdle;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      word_count <= '0;
      full       <= 1'b0;
      err        <= 1'b0;
    end else begin
      unique case (state)
        StIdle: begin
          if (in_valid && in_ready) begin
            if (illegal) begin
              err <= 1'b1;
            end else begin
              mem_wdata <= enc;
              mem_we    <= 1'b1;
              state     <= StWrite;
            end
          end
        end
        StWrite: begin
          mem_we   <= 1'b0;
          mem_addr <= mem_addr + ADDR_W'(1);
`ifdef ENC_WRAP_EN
          if (word_count != MaxCount) begin
            word_count <= word_count + (ADDR_W + 1)'(1);
          end
          state <= StIdle;
`else
          word_count <= word_count + (ADDR_W + 1)'(1);
          if (word_count == MaxCount - (ADDR_W + 1)'(1)) begin
            full  <= 1'b1;
            state <= StFull;
          end else begin
            state <= StIdle;
          end
`endif
        end
        StFull: begin
          state <= StFull;
        end
        default: begin
          state <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Randomized and directed bench for instr_encoder against a transaction-level reference model.
// Honours ENC_WRAP_EN so the same bench checks either full-memory behaviour.
module tb_instr_encoder;

  localparam int AW    = 2;
  localparam int DEPTH = 4;
`ifdef ENC_WRAP_EN
  localparam bit Wrap = 1'b1;
`else
  localparam bit Wrap = 1'b0;
`endif

  logic          clk, reset, in_valid, in_ready, clear;
  logic [3:0]    cond, rn, rd;
  logic [1:0]    op;
  logic [5:0]    funct;
  logic [23:0]   operand;
  logic          mem_we, full, err;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [AW:0]   word_count;

  instr_encoder #(.ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .cond(cond), .op(op), .funct(funct), .rn(rn), .rd(rd), .operand(operand),
    .clear(clear), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .word_count(word_count), .full(full), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vecs = 0;
  int errs = 0;

  // reference model state
  int          m_ptr, m_count;
  bit          m_err, m_full, m_busy, m_we;
  logic [31:0] m_word;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] encode(input int unsigned c, input int unsigned o,
                                         input int unsigned f, input int unsigned n,
                                         input int unsigned d, input int unsigned imm);
    if (o == 2) return (c << 28) | (2 << 26) | ((f / 16) << 24) | (imm % (1 << 24));
    return (c << 28) | (o << 26) | (f << 20) | (n << 16) | (d << 12) | (imm % 4096);
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_count = 0; m_err = 0; m_full = 0; m_busy = 0; m_we = 0; m_word = '0;
  endtask

  task automatic check_outputs(input string pfx);
    chk({pfx, ".mem_we"}, 32'(mem_we), 32'(m_we));
    chk({pfx, ".mem_addr"}, 32'(mem_addr), 32'(m_ptr));
    chk({pfx, ".mem_wdata"}, mem_wdata, m_word);
    chk({pfx, ".word_count"}, 32'(word_count), 32'(m_count));
    chk({pfx, ".full"}, 32'(full), 32'(m_full));
    chk({pfx, ".err"}, 32'(err), 32'(m_err));
  endtask

  // Called at posedge+1: drive a bundle, check in_ready, advance one edge, check outputs.
  task automatic step(input bit v, input logic [3:0] c, input logic [1:0] o,
                      input logic [5:0] f, input logic [3:0] n, input logic [3:0] d,
                      input logic [23:0] imm, input bit clr);
    bit ready;
    in_valid = v; cond = c; op = o; funct = f; rn = n; rd = d; operand = imm; clear = clr;
    #1;
    ready = !m_busy && !m_full && !clr;
    chk("in_ready", 32'(in_ready), 32'(ready));
    if (clr) begin
      m_ptr = 0; m_count = 0; m_err = 0; m_full = 0; m_busy = 0; m_we = 0;
    end else if (m_busy) begin
      m_we = 0; m_busy = 0;
      m_ptr = (m_ptr + 1) % DEPTH;
      if (Wrap) m_count = (m_count + 1 > DEPTH) ? DEPTH : m_count + 1;
      else begin
        m_count = m_count + 1;
        if (m_count == DEPTH) m_full = 1;
      end
    end else if (v && ready) begin
      if (o == 2'b11 || c == 4'hF) m_err = 1;
      else begin
        m_busy = 1; m_we = 1; m_word = encode(c, o, f, n, d, imm);
      end
    end
    @(posedge clk);
    #1;
    check_outputs("step");
  endtask

  task automatic idle();
    step(1'b0, 4'hE, 2'b00, 6'h00, 4'h0, 4'h0, 24'h0, 1'b0);
  endtask

  initial begin
    reset = 1'b0; in_valid = 1'b0; clear = 1'b0;
    cond = '0; op = '0; funct = '0; rn = '0; rd = '0; operand = '0;
    model_reset();
    #1;
    check_outputs("reset");
    chk("reset.in_ready", 32'(in_ready), 32'(0));
    @(posedge clk); #1;
    reset = 1'b1;

    // ADD R1,R2,#5
    step(1'b1, 4'hE, 2'b00, 6'b101000, 4'd2, 4'd1, 24'h000005, 1'b0);
    chk("add.wdata", mem_wdata, 32'hE282_1005);
    chk("add.addr", 32'(mem_addr), 32'd0);
    chk("add.we", 32'(mem_we), 32'd1);
    idle();
    chk("add.count", 32'(word_count), 32'd1);
    // LDR R3,[R4,#8]
    step(1'b1, 4'hE, 2'b01, 6'b011001, 4'd4, 4'd3, 24'h000008, 1'b0);
    chk("ldr.wdata", mem_wdata, 32'hE594_3008);
    chk("ldr.addr", 32'(mem_addr), 32'd1);
    idle();
    // branch, rn/rd ignored
    step(1'b1, 4'hE, 2'b10, 6'b101111, 4'd7, 4'd9, 24'h000003, 1'b0);
    chk("b.wdata", mem_wdata, 32'hEA00_0003);
    idle();
    // illegal op, then illegal cond
    step(1'b1, 4'hE, 2'b11, 6'h00, 4'd1, 4'd1, 24'h0, 1'b0);
    chk("ill.err", 32'(err), 32'd1);
    chk("ill.we", 32'(mem_we), 32'd0);
    chk("ill.count", 32'(word_count), 32'd3);
    step(1'b1, 4'hF, 2'b00, 6'h00, 4'd1, 4'd1, 24'h0, 1'b0);
    idle();
    chk("ill.sticky", 32'(err), 32'd1);
    step(1'b0, 4'hE, 2'b00, 6'h00, 4'd0, 4'd0, 24'h0, 1'b1);
    chk("clr.err", 32'(err), 32'd0);
    // clear together with in_valid: no acceptance
    step(1'b1, 4'hE, 2'b00, 6'h01, 4'd1, 4'd1, 24'h1, 1'b1);
    chk("clrv.we", 32'(mem_we), 32'd0);

    // in_valid held high until memory fills (and wraps when enabled)
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 4'h0, 2'b00, 6'(i), 4'(i), 4'(i + 1), 24'(i * 3), 1'b0);
    end
`ifdef ENC_WRAP_EN
    chk("wrap.full", 32'(full), 32'd0);
    chk("wrap.count", 32'(word_count), 32'd4);
`else
    chk("fill.full", 32'(full), 32'd1);
    chk("fill.ready", 32'(in_ready), 32'd0);
`endif
    step(1'b0, 4'hE, 2'b00, 6'h00, 4'd0, 4'd0, 24'h0, 1'b1);

    // reset pulled during a WRITE cycle aborts it at once
    step(1'b1, 4'h3, 2'b01, 6'h2A, 4'd5, 4'd6, 24'h123, 1'b0);
    chk("rw.we_before", 32'(mem_we), 32'd1);
    #2 reset = 1'b0;
    #1;
    model_reset();
    check_outputs("rw");
    chk("rw.in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    step(1'b1, 4'hE, 2'b00, 6'b101000, 4'd2, 4'd1, 24'h000005, 1'b0);
    chk("rw.first_accept", 32'(mem_we), 32'd1);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
           6'($urandom), 4'($urandom), 4'($urandom), 24'($urandom),
           ($urandom_range(0, 15) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
